// File: rtl/pong_ball.sv
// rtl/pong_ball.sv - Pong ball motion, wall/paddle bounce, miss detection and score pulses
module pong_ball #(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int BALL_SIZE      = 8,
   parameter int PADDLE_W       = 8,
   parameter int PADDLE_H       = 64,
   parameter int LEFT_PADDLE_X  = 16,
   parameter int RIGHT_PADDLE_X = 616,
   parameter int DX             = 2,
   parameter int DY             = 2,
   parameter int SERVE_FRAMES   = 60,
   parameter int XBIT_WIDTH     = 9,
   parameter int YBIT_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  start,
   input  logic [YBIT_WIDTH:0]   left_paddle_y,
   input  logic [YBIT_WIDTH:0]   right_paddle_y,
   output logic [XBIT_WIDTH:0]   ball_x,
   output logic [YBIT_WIDTH:0]   ball_y,
   output logic                  serving,
   output logic                  hit,
   output logic                  score_left,
   output logic                  score_right
);

   // bus widths, and one-bit-wider widths so comparisons never wrap
   localparam int XW = XBIT_WIDTH + 1;
   localparam int YW = YBIT_WIDTH + 1;
   localparam int XE = XBIT_WIDTH + 2;
   localparam int YE = YBIT_WIDTH + 2;
   localparam int CW = $clog2(SERVE_FRAMES + 1);

   localparam logic [XW-1:0] C_CX   = XW'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [YW-1:0] C_CY   = YW'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [XE-1:0] C_DX   = XE'(DX);
   localparam logic [XE-1:0] C_LF   = XE'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [XE-1:0] C_RF   = XE'(RIGHT_PADDLE_X - BALL_SIZE);
   localparam logic [XE-1:0] C_XMAX = XE'(SCREEN_W - BALL_SIZE);
   localparam logic [YE-1:0] C_DY   = YE'(DY);
   localparam logic [YE-1:0] C_BALL = YE'(BALL_SIZE);
   localparam logic [YE-1:0] C_H    = YE'(SCREEN_H);
   localparam logic [YE-1:0] C_YMAX = YE'(SCREEN_H - BALL_SIZE);
   localparam logic [YE-1:0] C_PH   = YE'(PADDLE_H);
   localparam logic [CW-1:0] C_LAST = CW'(SERVE_FRAMES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY} state_t;

   state_t        r_state;
   logic [XW-1:0] r_ball_x;
   logic [YW-1:0] r_ball_y;
   logic          r_vx;        // 1 = moving right
   logic          r_vy;        // 1 = moving down
   logic [CW-1:0] r_cnt;
   logic          r_serving;
   logic          r_hit;
   logic          r_score_left;
   logic          r_score_right;

   logic [XE-1:0] w_xe;
   logic [YE-1:0] w_ye;
   logic [YE-1:0] w_pl;
   logic [YE-1:0] w_pr;
   logic          w_ovl_l;
   logic          w_ovl_r;
   logic [XW-1:0] w_nx;
   logic [YW-1:0] w_ny;
   logic          w_nvx;
   logic          w_nvy;
   logic          w_hit;
   logic          w_sl;
   logic          w_sr;

   assign w_xe = {1'b0, r_ball_x};
   assign w_ye = {1'b0, r_ball_y};
   assign w_pl = {1'b0, left_paddle_y};
   assign w_pr = {1'b0, right_paddle_y};

   // strict overlap on both edges: a corner touch does not count as a hit
   assign w_ovl_l = (w_ye + C_BALL > w_pl) && (w_ye < w_pl + C_PH);
   assign w_ovl_r = (w_ye + C_BALL > w_pr) && (w_ye < w_pr + C_PH);

   // next ball position for a PLAY tick; X and Y resolved independently
   always_comb begin
      w_ny  = r_ball_y;
      w_nvy = r_vy;
      w_nx  = r_ball_x;
      w_nvx = r_vx;
      w_hit = 1'b0;
      w_sl  = 1'b0;
      w_sr  = 1'b0;
      if (!r_vy && (w_ye < C_DY)) begin
         w_ny  = '0;
         w_nvy = 1'b1;
      end else if (r_vy && (w_ye + C_BALL + C_DY > C_H)) begin
         w_ny  = YW'(C_YMAX);
         w_nvy = 1'b0;
      end else if (r_vy) begin
         w_ny = YW'(w_ye + C_DY);
      end else begin
         w_ny = YW'(w_ye - C_DY);
      end
      if (!r_vx) begin
         if ((w_xe >= C_LF) && (w_xe < C_LF + C_DX) && w_ovl_l) begin
            w_nx  = XW'(C_LF);
            w_nvx = 1'b1;
            w_hit = 1'b1;
         end else if (w_xe < C_DX) begin
            w_sr = 1'b1;
         end else begin
            w_nx = XW'(w_xe - C_DX);
         end
      end else begin
         if ((w_xe <= C_RF) && (w_xe + C_DX > C_RF) && w_ovl_r) begin
            w_nx  = XW'(C_RF);
            w_nvx = 1'b0;
            w_hit = 1'b1;
         end else if (w_xe + C_DX > C_XMAX) begin
            w_sl = 1'b1;
         end else begin
            w_nx = XW'(w_xe + C_DX);
         end
      end
   end

   // game FSM: idle, serve countdown, and per-frame ball update with registered pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ball_x      <= C_CX;
         r_ball_y      <= C_CY;
         r_vx          <= 1'b1;
         r_vy          <= 1'b1;
         r_cnt         <= '0;
         r_serving     <= 1'b1;
         r_hit         <= 1'b0;
         r_score_left  <= 1'b0;
         r_score_right <= 1'b0;
      end else begin
         r_hit         <= 1'b0;
         r_score_left  <= 1'b0;
         r_score_right <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ball_x <= C_CX;
               r_ball_y <= C_CY;
               if (start) begin
                  r_state <= S_SERVE;
                  r_cnt   <= '0;
                  r_vx    <= 1'b1;
               end
            end
            S_SERVE: begin
               r_ball_x <= C_CX;
               r_ball_y <= C_CY;
               if (frame_tick) begin
                  if (r_cnt == C_LAST) begin
                     r_state   <= S_PLAY;
                     r_cnt     <= '0;
                     r_serving <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (frame_tick) begin
                  if (w_sl || w_sr) begin
                     // a miss re-centres the ball and serves toward whoever conceded
                     r_state       <= S_SERVE;
                     r_cnt         <= '0;
                     r_serving     <= 1'b1;
                     r_ball_x      <= C_CX;
                     r_ball_y      <= C_CY;
                     r_vx          <= w_sl;
                     r_score_left  <= w_sl;
                     r_score_right <= w_sr;
                  end else begin
                     r_ball_x <= w_nx;
                     r_ball_y <= w_ny;
                     r_vx     <= w_nvx;
                     r_vy     <= w_nvy;
                     r_hit    <= w_hit;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_serving <= 1'b1;
            end
         endcase
      end
   end

   assign ball_x      = r_ball_x;
   assign ball_y      = r_ball_y;
   assign serving     = r_serving;
   assign hit         = r_hit;
   assign score_left  = r_score_left;
   assign score_right = r_score_right;

endmodule

// File: tb/tb_pong_ball.sv
// tb/tb_pong_ball.sv - directed self-checking bench for pong_ball
module tb_pong_ball;

   logic       clk;
   logic       rst_n;
   logic       frame_tick;
   logic       start;
   logic [8:0] left_paddle_y;
   logic [8:0] right_paddle_y;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       serving;
   logic       hit;
   logic       score_left;
   logic       score_right;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_hit  = 0;
   int n_sl   = 0;
   int n_sr   = 0;
   int n_multi = 0;

   pong_ball dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_tick     (frame_tick),
      .start          (start),
      .left_paddle_y  (left_paddle_y),
      .right_paddle_y (right_paddle_y),
      .ball_x         (ball_x),
      .ball_y         (ball_y),
      .serving        (serving),
      .hit            (hit),
      .score_left     (score_left),
      .score_right    (score_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // count pulses away from the active edge, and any cycle with two pulses at once
   always @(negedge clk) begin
      if (hit) n_hit++;
      if (score_left) n_sl++;
      if (score_right) n_sr++;
      if ((32'(hit) + 32'(score_left) + 32'(score_right)) > 1) n_multi++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_xy(input string tag, input int ex, input int ey);
      check({tag, ".x"}, 32'(ball_x), ex);
      check({tag, ".y"}, 32'(ball_y), ey);
   endtask

   task automatic check_pulses(input string tag, input int eh, input int esl, input int esr);
      check({tag, ".hit"}, 32'(hit), eh);
      check({tag, ".score_left"}, 32'(score_left), esl);
      check({tag, ".score_right"}, 32'(score_right), esr);
   endtask

   task automatic tick();
      @(posedge clk); #1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      frame_tick     = 1'b0;
      start          = 1'b0;
      left_paddle_y  = 9'd174;
      right_paddle_y = 9'd400;
      repeat (3) @(posedge clk);
      #1;
      check_xy("reset", 316, 236);
      check("reset.serving", 32'(serving), 1);
      check_pulses("reset", 0, 0, 0);
      rst_n = 1'b1;

      // ticks in IDLE do nothing
      ticks(2);
      check_xy("idle_tick", 316, 236);
      check("idle_tick.serving", 32'(serving), 1);

      // start and tick together: start wins, counter begins at zero
      @(posedge clk); #1;
      start = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      frame_tick = 1'b0;
      check("start.serving", 32'(serving), 1);
      ticks(30);
      pulse_start();
      ticks(28);
      tick();
      check("serve59.serving", 32'(serving), 1);
      check_xy("serve59", 316, 236);
      tick();
      check("serve60.serving", 32'(serving), 0);
      check_xy("serve60", 316, 236);
      tick();
      check_xy("play1", 318, 238);

      // bottom wall
      ticks(116);
      check_xy("n117", 550, 470);
      tick();
      check_xy("n118", 552, 472);
      tick();
      check_xy("n119_bounce", 554, 472);
      tick();
      check_xy("n120", 556, 470);

      // right paddle at 400: face reached without hit, then bounce
      ticks(26);
      check_xy("n146", 608, 418);
      check_pulses("n146", 0, 0, 0);
      tick();
      check_xy("rhit", 608, 416);
      check_pulses("rhit", 1, 0, 0);
      @(posedge clk); #1;
      check("rhit_after.hit", 32'(hit), 0);
      tick();
      check_xy("m1", 606, 414);

      // top wall
      ticks(206);
      check_xy("m207", 194, 2);
      tick();
      check_xy("m208", 192, 0);
      tick();
      check_xy("m209_bounce", 190, 0);
      tick();
      check_xy("m210", 188, 2);

      // left paddle at 174: ball bottom equals paddle top -> miss
      ticks(82);
      check_xy("m292", 24, 166);
      tick();
      check_xy("ledge_miss", 22, 168);
      check_pulses("ledge_miss", 0, 0, 0);
      ticks(11);
      check_xy("m304", 0, 190);
      tick();
      check_pulses("lmiss", 0, 0, 1);
      check("lmiss.serving", 32'(serving), 1);
      check_xy("lmiss", 316, 236);

      // serve toward left; left paddle at 425 overlaps by one pixel -> hit
      left_paddle_y = 9'd425;
      ticks(59);
      check("serve2_59.serving", 32'(serving), 1);
      tick();
      check("serve2_60.serving", 32'(serving), 0);
      tick();
      check_xy("k1", 314, 238);
      ticks(145);
      check_xy("k146", 24, 418);
      right_paddle_y = 9'd102;
      tick();
      check_xy("lhit", 24, 416);
      check_pulses("lhit", 1, 0, 0);
      tick();
      check_xy("j1", 26, 414);

      // right paddle at 102: ball top equals paddle bottom -> miss
      ticks(291);
      check_xy("j292", 608, 166);
      tick();
      check_xy("redge_miss", 610, 168);
      check_pulses("redge_miss", 0, 0, 0);
      ticks(11);
      check_xy("j304", 632, 190);
      tick();
      check_pulses("rmiss", 0, 1, 0);
      check("rmiss.serving", 32'(serving), 1);
      check_xy("rmiss", 316, 236);

      ticks(60);
      check("serve3.serving", 32'(serving), 0);
      tick();
      check_xy("serve3_p1", 318, 238);
      tick();
      check_xy("serve3_p2", 320, 240);

      // asynchronous reset between edges
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_xy("areset", 316, 236);
      check("areset.serving", 32'(serving), 1);
      #2;
      rst_n = 1'b1;
      ticks(3);
      check_xy("areset_idle", 316, 236);
      check("areset_idle.serving", 32'(serving), 1);
      pulse_start();
      ticks(60);
      check("restart.serving", 32'(serving), 0);
      tick();
      check_xy("restart_p1", 318, 238);

      @(posedge clk); #1;
      check("count.hit", n_hit, 2);
      check("count.score_left", n_sl, 1);
      check("count.score_right", n_sr, 1);
      check("count.exclusive", n_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Ball motion and collision engine for the two-player Pong game; directly downstream of the two paddle instances.
- Consumes both paddles' y positions and advances the ball once per video frame.
- Bounces the ball off the top/bottom walls and the paddle faces, detects misses, and emits score pulses for the scoreboard.
- Provides ball_x/ball_y to the pixel renderer.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball square edge in pixels
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- LEFT_PADDLE_X, 16, left paddle left edge x
- RIGHT_PADDLE_X, 616, right paddle left edge x
- DX, 2, horizontal step per frame
- DY, 2, vertical step per frame
- SERVE_FRAMES, 60, frame ticks of pause before each serve
- XBIT_WIDTH, 9, x bus MSB index (x bus is XBIT_WIDTH+1 bits)
- YBIT_WIDTH, 8, y bus MSB index (y bus is YBIT_WIDTH+1 bits; matches paddle yPos)

Ports:
- clk, input, 1, system clock; only clock in the block
- rst_n, input, 1, asynchronous active-low reset
- frame_tick, input, 1, one-cycle pulse per frame; all motion happens only on this cycle
- start, input, 1, one-cycle pulse that begins the game from IDLE
- left_paddle_y, input, YBIT_WIDTH+1, left paddle top edge
- right_paddle_y, input, YBIT_WIDTH+1, right paddle top edge
- ball_x, output, XBIT_WIDTH+1, ball left edge
- ball_y, output, YBIT_WIDTH+1, ball top edge
- serving, output, 1, high in IDLE and SERVE
- hit, output, 1, one-cycle pulse on a paddle bounce
- score_left, output, 1, one-cycle pulse when the right player misses
- score_right, output, 1, one-cycle pulse when the left player misses

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - state = IDLE
  - ball_x = CX = (SCREEN_W-BALL_SIZE)/2 = 316
  - ball_y = CY = (SCREEN_H-BALL_SIZE)/2 = 236
  - vx = +, vy = +
  - serve counter = 0
  - hit, score_left, score_right = 0; serving = 1
- rst_n asserted in any state returns everything to these values immediately.
- State IDLE:
  - Ball held at centre.
  - start → SERVE with counter cleared and vx = + (first serve goes right).
  - frame_tick is ignored.
- State SERVE:
  - Ball held at centre.
  - Each frame_tick increments the counter.
  - On the tick where counter == SERVE_FRAMES-1 → PLAY, counter cleared. Ball does not move on that tick.
  - start is ignored.
- State PLAY, on each frame_tick. X and Y axes are resolved independently on the same tick; all registered outputs update on the cycle after the tick.
- Y axis:
  - vy = − and ball_y < DY: ball_y = 0, vy = +.
  - vy = + and ball_y + BALL_SIZE + DY > SCREEN_H: ball_y = SCREEN_H − BALL_SIZE, vy = −.
  - Otherwise ball_y ± DY.
- Vertical overlap with a paddle at P: ball_y + BALL_SIZE > P and ball_y < P + PADDLE_H. Strict on both edges, so a corner touch is a miss.
- X axis, moving left (vx = −), left face LF = LEFT_PADDLE_X + PADDLE_W:
  - ball_x ≥ LF, ball_x − DX < LF, and overlap with left_paddle_y: ball_x = LF, vx = +, hit pulse.
  - Else ball_x < DX: score_right pulse, → SERVE, next serve vx = − (toward the player who conceded).
  - Else ball_x − DX.
- X axis, moving right (vx = +), right face RF = RIGHT_PADDLE_X − BALL_SIZE:
  - ball_x ≤ RF, ball_x + DX > RF, and overlap with right_paddle_y: ball_x = RF, vx = −, hit pulse.
  - Else ball_x + DX > SCREEN_W − BALL_SIZE: score_left pulse, → SERVE, next serve vx = +.
  - Else ball_x + DX.
- A miss on a tick overrides that tick's y update; the ball re-centres on entering SERVE. vy is preserved across serves.
- Arithmetic: all comparisons use unsigned values one bit wider than the bus, so subtraction never wraps. Positions never leave [0, SCREEN−BALL_SIZE].
- Pulses: hit, score_left and score_right are high for exactly one clk cycle, are mutually exclusive, and are 0 when no frame_tick occurs.
- A frame_tick and start in the same cycle while in IDLE: start wins and the tick is ignored.

Test Plan:
- Reset/idle: reset, then start; wait for 60 frame_ticks → serving drops after the 60th tick; ball at (316,236) until then; first PLAY tick gives ball_x = 318, ball_y = 238.
- Wall bounce: ball at y = 1, vy = − (reached by play), tick → ball_y = 0, vy = +; ball at y = 471, vy = +, tick → ball_y = 472, then 470.
- Right paddle hit: right_paddle_y = 200, ball_x = 607, ball_y = 230, vx = +, tick → ball_x = 608, hit = 1 for one cycle, vx = −; next tick ball_x = 606.
- Miss/score: right_paddle_y = 0, ball_y = 300, ball reaches x = 632 → score_left pulse, serving = 1, ball at (316,236); after 60 ticks ball moves +x. Mirror case: left miss → score_right pulse, serve goes −x.
- Edge overlap: left_paddle_y = 100, ball_y = 92 (bottom edge == paddle top) → miss, no hit. ball_y = 93 → hit.
- Async reset mid-PLAY: assert rst_n = 0 between clk edges → outputs at reset values before the next clk edge; state IDLE; start is required to resume.
